// File: rtl/pkt_hdr_capture.sv
// Serial header hunter: finds a maskable HDR_W-bit header in an MSB-first bit stream,
// then captures the PAY_W-bit payload that follows and presents it as a parallel word.
module pkt_hdr_capture #(
  parameter int                 HDR_W       = 8,
  parameter logic [HDR_W-1:0]   HDR_PATTERN = 8'b1011_0110,
  parameter logic [HDR_W-1:0]   HDR_MASK    = '1,
  parameter int                 PAY_W       = 16,
  parameter int                 CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             header_detected,
  output logic             payload_valid,
  output logic [PAY_W-1:0] payload_data,
  output logic             busy,
  output logic [CNT_W-1:0] hdr_count
);

  localparam int FILL_W = $clog2(HDR_W + 1);
  localparam int BCNT_W = $clog2(PAY_W + 1);

  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_CAPTURE = 1'b1;

  logic [0:0]        state;
  logic [HDR_W-1:0]  hist;
  logic [HDR_W-1:0]  next_hist;
  logic [FILL_W-1:0] fill;
  logic [PAY_W-1:0]  pay_sr;
  logic [PAY_W-1:0]  next_pay;
  logic [PAY_W:0]    pay_ext;
  logic [BCNT_W-1:0] bit_cnt;
  logic              hdr_match;
  logic              pay_done;

  // The payload shift goes through a one-bit-wider vector so PAY_W=1 needs no special case.
  always_comb begin
    next_hist = {hist[HDR_W-2:0], in_bit};
    pay_ext   = {pay_sr, in_bit};
    next_pay  = pay_ext[PAY_W-1:0];
    hdr_match = (fill >= FILL_W'(HDR_W - 1)) &&
                (((next_hist ^ HDR_PATTERN) & HDR_MASK) == '0);
    pay_done  = (bit_cnt == BCNT_W'(PAY_W - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_HUNT;
      hist            <= '0;
      fill            <= '0;
      pay_sr          <= '0;
      bit_cnt         <= '0;
      header_detected <= 1'b0;
      payload_valid   <= 1'b0;
      payload_data    <= '0;
      hdr_count       <= '0;
    end else begin
      header_detected <= 1'b0;
      payload_valid   <= 1'b0;
      if (in_valid) begin
        if (state == ST_HUNT) begin
          if (hdr_match) begin
            state           <= ST_CAPTURE;
            hist            <= '0;
            fill            <= '0;
            bit_cnt         <= '0;
            header_detected <= 1'b1;
            hdr_count       <= hdr_count + 1'b1;
          end else begin
            hist <= next_hist;
            if (fill != FILL_W'(HDR_W))
              fill <= fill + 1'b1;
          end
        end else begin
          pay_sr  <= next_pay;
          bit_cnt <= bit_cnt + 1'b1;
          // Last payload bit: publish the word and resume hunting on the very next bit.
          if (pay_done) begin
            payload_data  <= next_pay;
            payload_valid <= 1'b1;
            state         <= ST_HUNT;
            fill          <= '0;
            bit_cnt       <= '0;
          end
        end
      end
    end
  end

  assign busy = (state == ST_CAPTURE);

endmodule

// File: doc/pkt_hdr_capture.md
# pkt_hdr_capture

Parametrised successor to the serial header detector. Hunts a serial bit stream (MSB first, qualified by `in_valid`) for a configurable, maskable header. After a header match it captures a fixed-length payload that follows immediately, presents it as a parallel word with a one-cycle valid strobe, then resumes hunting. It sits between the serial deserialiser front end and the packet parsing logic, and also keeps a free-running count of detected headers for status registers.

## Interface
- `HDR_W`, 8: header length in bits; 2..32.
- `HDR_PATTERN`, 8'b1011_0110: header value, MSB is the first bit on the wire.
- `HDR_MASK`, all ones (HDR_W bits): 1 = bit compared, 0 = don't-care.
- `PAY_W`, 16: payload length in bits; 1..64.
- `CNT_W`, 8: width of `hdr_count`; ≥1.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_bit` is valid this cycle.
- `in_bit` in 1: serial data, MSB first.
- `header_detected` out 1: one-cycle pulse per matched header.
- `payload_valid` out 1: one-cycle pulse when `payload_data` is updated.
- `payload_data` out PAY_W: last captured payload; first received bit sits in bit PAY_W-1.
- `busy` out 1: high while in CAPTURE state.
- `hdr_count` out CNT_W: number of headers detected, modulo 2^CNT_W.

## Operation
- Two-state FSM:
  - HUNT: every accepted bit (`in_valid`=1) shifts into a HDR_W-bit history register, `hist <= {hist[HDR_W-2:0], in_bit}`. A fill counter saturates at HDR_W.
  - Match condition: the fill count including the current bit is ≥ HDR_W, and `((next_hist ^ HDR_PATTERN) & HDR_MASK) == 0`.
  - On a match: go to CAPTURE, clear the history and fill counter, clear the payload bit counter, and increment `hdr_count`.
  - CAPTURE: every accepted bit shifts into the payload shift register, and a bit counter counts up.
  - On the PAY_W-th accepted bit: load `payload_data` with the completed shift value, go to HUNT, and leave the fill counter at 0.
- Overlap behaviour:
  - Partial matches inside HUNT are handled naturally by the sliding history. A header preceded by a false-start prefix is still found.
  - Payload bits are never examined for headers.
- No dead cycles. The first accepted bit after the last payload bit is the first hunted bit. The first payload bit may arrive on the cycle immediately after the last header bit.
- `in_valid`=0: no register changes, no pulses, state is held.
- `hdr_count` wraps from 2^CNT_W-1 to 0 with no saturation.
- `payload_data` holds its value between captures.

## Timing
- All outputs are registered.
- `header_detected` is high for exactly the one cycle after the clock edge that accepted the last header bit.
- `busy` rises in that same cycle.
- `payload_valid` is high for exactly the one cycle after the edge that accepted the last payload bit. `payload_data` is valid from that cycle onward. `busy` falls in that same cycle.
- `header_detected` and `payload_valid` are never high in the same cycle. The minimum spacing between them is PAY_W accepted bits (header to payload) and HDR_W accepted bits (payload to next header).
- Reset values: state HUNT, history 0, fill 0, `header_detected` 0, `payload_valid` 0, `payload_data` 0, `busy` 0, `hdr_count` 0.
- Reset mid-CAPTURE aborts the partial payload. No `payload_valid` is produced, and `payload_data` goes to 0 immediately (asynchronous).
- After reset deassertion, the first HDR_W accepted bits fill the history. A match is possible no earlier than the HDR_W-th accepted bit.

## Test plan
1. **Basic capture.** Defaults. Send 1011_0110 then 0xA5C3 MSB first, one bit per cycle.
   - `header_detected` pulses one cycle after bit 8.
   - `busy` is high for 16 cycles.
   - `payload_valid` pulses one cycle after bit 24, with `payload_data`=0xA5C3.
   - `hdr_count`=1.
2. **False start and back-to-back packets.** Send 1011_1011_0110.
   - Detection occurs only after bit 12.
   - Then send 16 payload bits, immediately followed by 1011_0110 plus a payload.
   - Expect a second `header_detected` exactly 8 cycles after the first `payload_valid`.
3. **Valid gaps.** Repeat scenario 1 with `in_valid` toggled 1,0,0,1,…
   - Pulses are delayed to the cycle after the last accepted bit.
   - Values are identical.
   - No pulse occurs while `in_valid`=0.
4. **Mask.** Configure HDR_MASK=8'hF0 and send 1011_0001.
   - `header_detected` pulses.
   - With the default mask the same stream gives no pulse.
5. **Async reset mid-payload.** Assert `rst` after 5 payload bits, between clock edges.
   - All outputs go to 0 immediately.
   - After release, a full packet captures correctly and `hdr_count`=1.
6. **Counter wrap.** Configure CNT_W=2 and send 5 packets.
   - `hdr_count` sequence is 1, 2, 3, 0, 1.
   - 5 `payload_valid` pulses with correct data.
